uart_cmd_parser: RTL
====================

Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver. Consumes its byte stream (8-bit data plus a 1-cycle valid pulse) and assembles fixed-format command frames from the host/Bluetooth link.
- Delivers validated commands (opcode, length, up to MAX_LEN payload bytes) to the car control logic as one pulse.
- Rejects malformed, checksum-failing or stalled frames and reports them through an error pulse and code.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- UART_BPS, 115200, link baud rate; used only to size the inter-byte timeout.
- MAX_LEN, 4, maximum payload bytes per frame (1..15).
- TIMEOUT_BYTES, 4, allowed silence inside a frame, in byte times (1 byte time = 10 bit times).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- in_data  in  8  received byte; valid only when in_flag=1.
- in_flag  in  1  1-cycle byte-valid strobe.
- cmd_valid  out  1  1-cycle pulse: a complete, verified frame has been received.
- cmd_op  out  8  opcode of the last good frame; held until the next good frame.
- cmd_len  out  4  payload length of the last good frame.
- cmd_payload  out  8*MAX_LEN  payload; byte i at [8i+7:8i]; bytes at index >= cmd_len are zero.
- err_pulse  out  1  1-cycle pulse: the frame was dropped.
- err_code  out  3  reason for the last error; held until the next error.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). Sampled only on the rising edge of clk.
- Frame format: 0xAA, OP, LEN, LEN payload bytes, CHK, 0x55.
  - CHK = (OP + LEN + sum of payload) mod 256.
- Reset values:
  - All outputs 0.
  - State IDLE; timeout counter 0; internal payload buffer and running sum 0.
  - A reset mid-frame discards the partial frame and raises no error.
- FSM states: IDLE, OP, LEN, DATA, CHK, TAIL. Transitions happen only on cycles with in_flag=1, except timeout.
  - IDLE: byte 0xAA -> OP and clear the running sum. Any other byte is silently discarded.
  - OP: store the opcode, add it to the sum -> LEN.
  - LEN:
    - value > MAX_LEN -> err_code=1, go to IDLE.
    - value = 0 -> CHK.
    - otherwise -> DATA with the byte index cleared.
    - The value is always added to the sum.
  - DATA: write the byte to buffer[index], add it to the sum, increment the index. After the LEN-th byte -> CHK.
  - CHK: byte != sum -> err_code=2, go to IDLE. Otherwise -> TAIL.
  - TAIL:
    - byte = 0x55 -> publish outputs, go to IDLE.
    - byte != 0x55 -> err_code=3, go to IDLE.
- An error byte is never reinterpreted as a header; resynchronisation needs a fresh 0xAA.
- Output latency:
  - cmd_valid rises in the cycle after the in_flag carrying the tail byte.
  - cmd_op, cmd_len and cmd_payload update in that same cycle.
  - Unused payload bytes are zero-filled at publish time.
  - err_pulse and err_code likewise appear 1 cycle after the offending byte.
- Timeout:
  - TIMEOUT_CLKS = (CLK_FREQ/UART_BPS)*10*TIMEOUT_BYTES.
  - The counter runs in any state except IDLE and clears on every in_flag.
  - At TIMEOUT_CLKS-1: err_pulse, err_code=4, go to IDLE.
  - If in_flag arrives in the same cycle the counter hits its limit, the byte wins: it is processed and the counter clears.
- cmd_valid and err_pulse are never asserted in the same cycle.
- Back-to-back frames with zero idle between bytes are supported, since in_flag arrives at most once per byte time.
- Arithmetic: the sum is 8-bit and wraps modulo 256. The index is 4 bits.

Decomposition:
- Shared package: the header constant 0xAA, the tail constant 0x55, the error codes (0 none, 1 bad length, 2 bad checksum, 3 bad tail, 4 timeout) and the FSM state encoding.
- One natural sub-module: uart_cmd_timeout, a loadable down-counter with clear and expire-pulse, parameterised by TIMEOUT_CLKS.

Test Plan:
- Good frame: AA 01 02 10 20 33 55.
  - Expect cmd_valid one cycle after the 55 byte, cmd_op=01, cmd_len=2, cmd_payload=0x0000_2010.
  - No err_pulse.
- Zero-length frame with leading garbage: 00 FF AA 07 00 07 55.
  - Garbage ignored; cmd_valid with cmd_op=07, cmd_len=0, payload=0.
- Bad checksum: AA 01 02 10 20 34 55.
  - err_pulse with err_code=2 one cycle after the 34 byte.
  - No cmd_valid; previous cmd_* outputs unchanged.
  - The trailing 55 is ignored in IDLE.
- Bad length (MAX_LEN=4): AA 03 05.
  - err_code=1 after the 05 byte.
  - Then AA 03 01 09 0D 55 -> cmd_valid, payload byte0=09.
- Timeout: AA 01, then silence.
  - err_code=4 exactly TIMEOUT_CLKS cycles after the 01 strobe.
  - Also drive a byte on the limit cycle: it must be accepted with no timeout.
- Reset mid-frame: AA 01 02 10, assert rst for 1 cycle, then a good frame.
  - No error pulse from the reset.
  - Outputs cleared, then the new frame is decoded correctly.

Source files
------------

// File: rtl/uart_cmd_parser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_parser_pkg
//  Description : Shared framing constants, error codes and parser state
//                encoding for the UART command parser.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_cmd_parser_pkg;

  // Frame delimiters
  localparam logic [7:0] c_HEADER = 8'hAA;
  localparam logic [7:0] c_TAIL   = 8'h55;

  // Error codes reported on err_code
  localparam logic [2:0] c_ERR_NONE    = 3'd0;
  localparam logic [2:0] c_ERR_BAD_LEN = 3'd1;
  localparam logic [2:0] c_ERR_BAD_CHK = 3'd2;
  localparam logic [2:0] c_ERR_BAD_TAIL = 3'd3;
  localparam logic [2:0] c_ERR_TIMEOUT = 3'd4;

  // Parser states: each names the field the next byte is expected to be
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OP   = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_TAIL = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_timeout
//  Description : Inter-byte silence watchdog. Loadable down-counter that is
//                reloaded on every received byte and emits a one-cycle
//                expire indication once TIMEOUT_CLKS cycles of silence have
//                elapsed since the last load.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk       in   system clock
//    rst       in   synchronous reset, active-high
//    i_load    in   byte strobe; restarts the silence window
//    i_en      in   count enable (parser is inside a frame)
//    o_expire  out  combinational; high in the last cycle of the window
// ============================================================================
module uart_cmd_timeout #(
  parameter int TIMEOUT_CLKS = 17360   // must be >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  // The load cycle itself is cycle 0 of the window, so after the load the
  // counter sits at TIMEOUT_CLKS-2 and reaches zero in cycle TIMEOUT_CLKS-1
  // counted from the strobe. The parser registers the error one cycle
  // later, i.e. TIMEOUT_CLKS cycles after the last byte.
  localparam logic [CNT_W-1:0] c_LOAD = CNT_W'(TIMEOUT_CLKS - 2);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= c_LOAD;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // A byte arriving on the limit cycle wins over the expiry
  assign o_expire = i_en && !i_load && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_parser
//  Description : Assembles framed commands (AA OP LEN payload CHK 55) from a
//                UART byte stream, verifies them and publishes good frames
//                as a single pulse; drops bad or stalled frames with an
//                error pulse and reason code.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk          in   system clock
//    rst          in   synchronous reset, active-high
//    in_data      in   received byte, qualified by in_flag
//    in_flag      in   one-cycle byte-valid strobe
//    cmd_valid    out  one-cycle pulse, verified frame published
//    cmd_op       out  opcode of last good frame
//    cmd_len      out  payload length of last good frame
//    cmd_payload  out  payload, byte i at [8i+7:8i], unused bytes zero
//    err_pulse    out  one-cycle pulse, frame dropped
//    err_code     out  reason for last error
// ============================================================================
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int UART_BPS      = 115200,
  parameter int MAX_LEN       = 4,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_flag,
  output logic                 cmd_valid,
  output logic [7:0]           cmd_op,
  output logic [3:0]           cmd_len,
  output logic [8*MAX_LEN-1:0] cmd_payload,
  output logic                 err_pulse,
  output logic [2:0]           err_code
);

  localparam int TIMEOUT_CLKS = (CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_sum;
  logic [7:0]           r_op;
  logic [3:0]           r_len;
  logic [3:0]           r_idx;
  logic [7:0]           r_buf [MAX_LEN];
  logic [8*MAX_LEN-1:0] w_payload;
  logic                 w_publish;
  logic                 w_err;
  logic [2:0]           w_err_code;
  logic                 w_expire;

  uart_cmd_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_load   (in_flag),
    .i_en     (r_state != ST_IDLE),
    .o_expire (w_expire)
  );

  // Buffer slots beyond the frame length may hold bytes of an older frame
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_payload
    assign w_payload[8*gi +: 8] = (4'(gi) < r_len) ? r_buf[gi] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_publish   = 1'b0;
    w_err       = 1'b0;
    w_err_code  = c_ERR_NONE;
    if (in_flag) begin
      case (r_state)
        ST_IDLE: if (in_data == c_HEADER) w_state_nxt = ST_OP;
        ST_OP:   w_state_nxt = ST_LEN;
        ST_LEN: begin
          if (in_data > 8'(MAX_LEN)) begin
            w_err       = 1'b1;
            w_err_code  = c_ERR_BAD_LEN;
            w_state_nxt = ST_IDLE;
          end else if (in_data == 8'h00) begin
            w_state_nxt = ST_CHK;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
        ST_DATA: if (r_idx == r_len - 4'd1) w_state_nxt = ST_CHK;
        ST_CHK: begin
          if (in_data != r_sum) begin
            w_err       = 1'b1;
            w_err_code  = c_ERR_BAD_CHK;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_TAIL;
          end
        end
        ST_TAIL: begin
          w_state_nxt = ST_IDLE;
          if (in_data == c_TAIL) begin
            w_publish = 1'b1;
          end else begin
            w_err      = 1'b1;
            w_err_code = c_ERR_BAD_TAIL;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (w_expire) begin
      w_err       = 1'b1;
      w_err_code  = c_ERR_TIMEOUT;
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum       <= 8'h00;
      r_op        <= 8'h00;
      r_len       <= 4'd0;
      r_idx       <= 4'd0;
      for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= 8'h00;
      cmd_valid   <= 1'b0;
      cmd_op      <= 8'h00;
      cmd_len     <= 4'd0;
      cmd_payload <= '0;
      err_pulse   <= 1'b0;
      err_code    <= c_ERR_NONE;
    end else begin
      cmd_valid <= w_publish;
      err_pulse <= w_err;
      if (w_err) err_code <= w_err_code;
      if (w_publish) begin
        cmd_op      <= r_op;
        cmd_len     <= r_len;
        cmd_payload <= w_payload;
      end
      if (in_flag) begin
        case (r_state)
          ST_IDLE: if (in_data == c_HEADER) r_sum <= 8'h00;
          ST_OP: begin
            r_op  <= in_data;
            r_sum <= r_sum + in_data;
          end
          ST_LEN: begin
            r_len <= in_data[3:0];
            r_sum <= r_sum + in_data;
            r_idx <= 4'd0;
          end
          ST_DATA: begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (r_idx == 4'(i)) r_buf[i] <= in_data;
            end
            r_sum <= r_sum + in_data;
            r_idx <= r_idx + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
